comparator_seq_nbit: RTL and testbench
======================================

# comparator_seq_nbit

Sequential, parametrised magnitude comparator that succeeds the fixed 4-bit combinational comparator. It accepts two WIDTH-bit operands over a valid/ready handshake and compares them MSB-first, CHUNK bits per cycle, stopping at the first differing chunk. It returns a registered one-hot greater/equal/less result over a second valid/ready handshake. It sits between operand producers and control logic where wide compares must not sit on a single-cycle critical path.

## Interface
- WIDTH, 16: operand width in bits; must be a multiple of CHUNK and ≥ CHUNK.
- CHUNK, 4: bits compared per cycle; N = WIDTH/CHUNK chunks.

- clk  input  1  sole clock, rising-edge.
- rst  input  1  reset, asynchronous, active-high.
- in_valid  input  1  operand pair valid.
- in_ready  output  1  block can accept an operand pair.
- A  input  WIDTH  first operand.
- B  input  WIDTH  second operand.
- signed_mode  input  1  two's-complement compare; port exists only with CMP_SIGNED_EN.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- A_greater  output  1  A > B.
- A_equal  output  1  A == B.
- A_less  output  1  A < B.

## Operation
- The FSM has three states: IDLE, CMP and DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready: capture A, B (and signed_mode) into internal regs.
  - Set chunk index idx=N-1, clear result flags to 000, go to CMP.
- CMP:
  - in_ready=0.
  - Each cycle, compare chunk idx of the captured A against chunk idx of the captured B, unsigned.
  - Chunks differ: set A_greater or A_less accordingly, go to DONE.
  - Chunks equal and idx==0: set A_equal, go to DONE.
  - Otherwise: idx=idx-1, stay in CMP.
- DONE:
  - out_valid=1; flags held stable and one-hot.
  - On out_ready: go to IDLE.
  - Flags keep their value until the next capture clears them.
- Transfer rules:
  - A transfer occurs only on a rising edge with valid&ready both high.
  - in_valid is ignored outside IDLE; no overlap between transactions.
- Flags are registered outputs, never combinational from A/B.
- N=1 (WIDTH==CHUNK) is legal: every compare resolves in a single CMP cycle.

## Timing
- Reset values:
  - State returns to IDLE.
  - A_greater=A_equal=A_less=0, out_valid=0.
  - idx and captured operands are 0.
  - in_ready follows state decode: 0 while rst is high, 1 after release.
- Latency: accept edge E0, then decision at CMP edge Ek, where k = 1 + (number of equal leading chunks), so 1 ≤ k ≤ N.
  - out_valid rises after Ek, i.e. k cycles after accept.
  - Equal operands always take k=N.
- Throughput: at most one result per k+2 cycles.
  - Includes one DONE cycle minimum and the return to IDLE.
- Backpressure: with out_ready low, DONE persists indefinitely, flags and out_valid stay stable, and in_ready stays 0.
- Reset mid-operation (CMP or DONE):
  - Immediate return to IDLE with all outputs 0.
  - The in-flight result is discarded and never presented.

## Configuration
- CMP_SIGNED_EN defined:
  - signed_mode port present and sampled at capture.
  - When 1, the sign bit (bit WIDTH-1) of both captured operands is inverted at capture, so the unsigned chunk compare yields a two's-complement ordering.
  - When 0, behaviour is unsigned.
- CMP_SIGNED_EN undefined: port absent; all compares unsigned.

## Test plan
All scenarios use WIDTH=16, CHUNK=4.
- A=0x1234, B=0x0234 -> A_greater=1, out_valid 1 cycle after accept (k=1).
- A=B=0xBEEF -> A_equal=1, out_valid 4 cycles after accept (k=4).
- A=0x0120, B=0x0130 -> A_less=1, k=3; then A=0x0005, B=0x0004 back-to-back -> A_greater=1, k=4, flags cleared to 000 at the second capture.
- A=0x00FF, B=0x00FE with out_ready held low 5 cycles -> out_valid and A_greater=1 stable for all 5 cycles, in_ready=0, and a new in_valid pulse is ignored; result consumed when out_ready rises.
- CMP_SIGNED_EN: A=0xFFFF, B=0x0001 -> signed_mode=1 gives A_less=1 (k=1); signed_mode=0 gives A_greater=1 (k=1).
- A=0x0000, B=0x0001, rst pulsed at the second CMP cycle -> out_valid=0 and flags 000 immediately, never asserted for that transaction; next transaction A=0x9000, B=0x8000 -> A_greater=1, k=1.

Source files
------------

// File: rtl/comparator_seq_nbit_if.sv
// Operand/result handshake bundle for comparator_seq_nbit.
// signed_mode exists only when CMP_SIGNED_EN is defined.
interface comparator_seq_nbit_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
`ifdef CMP_SIGNED_EN
  logic             signed_mode;
`endif
  logic             out_valid;
  logic             out_ready;
  logic             A_greater;
  logic             A_equal;
  logic             A_less;

`ifdef CMP_SIGNED_EN
  modport master (
    output in_valid, A, B, signed_mode, out_ready,
    input  in_ready, out_valid, A_greater, A_equal, A_less
  );
  modport slave (
    input  in_valid, A, B, signed_mode, out_ready,
    output in_ready, out_valid, A_greater, A_equal, A_less
  );
`else
  modport master (
    output in_valid, A, B, out_ready,
    input  in_ready, out_valid, A_greater, A_equal, A_less
  );
  modport slave (
    input  in_valid, A, B, out_ready,
    output in_ready, out_valid, A_greater, A_equal, A_less
  );
`endif
endinterface

// File: rtl/comparator_seq_nbit.sv
// Sequential MSB-first magnitude comparator, CHUNK bits per cycle, early exit.
// Optional two's-complement mode enabled by defining CMP_SIGNED_EN.
module comparator_seq_nbit #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  comparator_seq_nbit_if.slave io_bus
);

  localparam int N    = WIDTH / CHUNK;
  localparam int IDXW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMP  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                  r_state;
  state_t                  w_nextState;
  logic [WIDTH-1:0]        r_a;
  logic [WIDTH-1:0]        r_b;
  logic [IDXW-1:0]         r_idx;
  logic                    r_gt;
  logic                    r_eq;
  logic                    r_lt;

  logic [WIDTH-1:0]        w_capA;
  logic [WIDTH-1:0]        w_capB;
  logic [N-1:0][CHUNK-1:0] w_aChunks;
  logic [N-1:0][CHUNK-1:0] w_bChunks;
  logic [CHUNK-1:0]        w_chunkA;
  logic [CHUNK-1:0]        w_chunkB;
  logic                    w_inReady;
  logic                    w_accept;
  logic                    w_chunkGt;
  logic                    w_chunkLt;
  logic                    w_lastChunk;

  // Flipping both sign bits maps two's-complement order onto unsigned order.
`ifdef CMP_SIGNED_EN
  assign w_capA = io_bus.A ^ {io_bus.signed_mode, {(WIDTH-1){1'b0}}};
  assign w_capB = io_bus.B ^ {io_bus.signed_mode, {(WIDTH-1){1'b0}}};
`else
  assign w_capA = io_bus.A;
  assign w_capB = io_bus.B;
`endif

  assign w_aChunks   = r_a;
  assign w_bChunks   = r_b;
  assign w_chunkA    = w_aChunks[r_idx];
  assign w_chunkB    = w_bChunks[r_idx];
  assign w_chunkGt   = (w_chunkA > w_chunkB);
  assign w_chunkLt   = (w_chunkA < w_chunkB);
  assign w_lastChunk = (r_idx == '0);

  assign w_inReady = (r_state == IDLE) && !rst;
  assign w_accept  = w_inReady && io_bus.in_valid;

  assign io_bus.in_ready  = w_inReady;
  assign io_bus.out_valid = (r_state == DONE);
  assign io_bus.A_greater = r_gt;
  assign io_bus.A_equal   = r_eq;
  assign io_bus.A_less    = r_lt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept) w_nextState = CMP;
      end
      CMP: begin
        if (w_chunkGt || w_chunkLt || w_lastChunk) w_nextState = DONE;
      end
      DONE: begin
        if (io_bus.out_ready) w_nextState = IDLE;
      end
      default: w_nextState = IDLE;
    endcase
  end

  // Flags are cleared only by a new capture so they stay readable after DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a   <= '0;
      r_b   <= '0;
      r_idx <= '0;
      r_gt  <= 1'b0;
      r_eq  <= 1'b0;
      r_lt  <= 1'b0;
    end else if (w_accept) begin
      r_a   <= w_capA;
      r_b   <= w_capB;
      r_idx <= IDXW'(N - 1);
      r_gt  <= 1'b0;
      r_eq  <= 1'b0;
      r_lt  <= 1'b0;
    end else if (r_state == CMP) begin
      if (w_chunkGt) begin
        r_gt <= 1'b1;
      end else if (w_chunkLt) begin
        r_lt <= 1'b1;
      end else if (w_lastChunk) begin
        r_eq <= 1'b1;
      end else begin
        r_idx <= r_idx - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_comparator_seq_nbit.sv
// Self-checking bench for comparator_seq_nbit: directed scenarios plus random
// transactions against an arithmetic reference model.
module tb_comparator_seq_nbit;

  localparam int WIDTH = 16;
  localparam int CHUNK = 4;
  localparam int N     = WIDTH / CHUNK;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  comparator_seq_nbit_if #(.WIDTH(WIDTH)) io ();

  comparator_seq_nbit #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
    .clk    (clk),
    .rst    (rst),
    .io_bus (io.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: ordering from plain integer compare; latency from the highest differing bit.
  task automatic refModel(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic sm,
                          output logic [2:0] flags, output int k);
    logic [WIDTH-1:0] diff;
    int               top;
    if (sm) begin
      if ($signed(a) > $signed(b))      flags = 3'b100;
      else if ($signed(a) < $signed(b)) flags = 3'b001;
      else                              flags = 3'b010;
    end else begin
      if (a > b)      flags = 3'b100;
      else if (a < b) flags = 3'b001;
      else            flags = 3'b010;
    end
    diff = a ^ b;
    top  = -1;
    for (int i = 0; i < WIDTH; i++) if (diff[i]) top = i;
    k = (top < 0) ? N : (N - top / CHUNK);
  endtask

  task automatic applyStimulus(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic sm);
    @(negedge clk);
    io.A        = a;
    io.B        = b;
`ifdef CMP_SIGNED_EN
    io.signed_mode = sm;
`endif
    io.in_valid = 1'b1;
    checkValue("acceptReady", 32'(io.in_ready), 32'd1);
    @(posedge clk);
    #1;
    io.in_valid = 1'b0;
    checkValue("flagsClearedAtCapture", 32'({io.A_greater, io.A_equal, io.A_less}), 32'd0);
    checkValue("busyNotReady", 32'(io.in_ready), 32'd0);
  endtask

  task automatic checkOutput(input logic [2:0] expFlags, input int expK, input int holdCycles);
    int cycles;
    cycles       = 0;
    io.out_ready = (holdCycles == 0);
    while (!io.out_valid && cycles < 50) begin
      @(posedge clk);
      #1;
      cycles++;
    end
    checkValue("latency", 32'(cycles), 32'(expK));
    checkValue("flags", 32'({io.A_greater, io.A_equal, io.A_less}), 32'(expFlags));
    for (int h = 0; h < holdCycles; h++) begin
      checkValue("holdValid", 32'(io.out_valid), 32'd1);
      checkValue("holdFlags", 32'({io.A_greater, io.A_equal, io.A_less}), 32'(expFlags));
      checkValue("holdNotReady", 32'(io.in_ready), 32'd0);
      io.in_valid = (h == 1);
      io.A        = 16'h1111;
      io.B        = 16'h2222;
      @(posedge clk);
      #1;
    end
    io.in_valid  = 1'b0;
    io.out_ready = 1'b1;
    @(posedge clk);
    #1;
    checkValue("consumedValid", 32'(io.out_valid), 32'd0);
    checkValue("idleReady", 32'(io.in_ready), 32'd1);
    checkValue("flagsHeld", 32'({io.A_greater, io.A_equal, io.A_less}), 32'(expFlags));
  endtask

  initial begin
    logic [WIDTH-1:0] ra;
    logic [WIDTH-1:0] rb;
    logic             rsm;
    logic [2:0]       expFlags;
    int               expK;

    checks       = 0;
    errors       = 0;
    rst          = 1'b1;
    io.in_valid  = 1'b0;
    io.out_ready = 1'b1;
    io.A         = '0;
    io.B         = '0;
`ifdef CMP_SIGNED_EN
    io.signed_mode = 1'b0;
`endif
    #1;
    checkValue("rstReady", 32'(io.in_ready), 32'd0);
    checkValue("rstValid", 32'(io.out_valid), 32'd0);
    checkValue("rstFlags", 32'({io.A_greater, io.A_equal, io.A_less}), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    checkValue("releaseReady", 32'(io.in_ready), 32'd1);

    applyStimulus(16'h1234, 16'h0234, 1'b0);
    checkOutput(3'b100, 1, 0);

    applyStimulus(16'hBEEF, 16'hBEEF, 1'b0);
    checkOutput(3'b010, 4, 0);

    applyStimulus(16'h0120, 16'h0130, 1'b0);
    checkOutput(3'b001, 3, 0);
    applyStimulus(16'h0005, 16'h0004, 1'b0);
    checkOutput(3'b100, 4, 0);

    // Backpressure with an ignored in_valid pulse during DONE.
    io.out_ready = 1'b0;
    applyStimulus(16'h00FF, 16'h00FE, 1'b0);
    checkOutput(3'b100, 4, 5);
    repeat (3) begin
      @(posedge clk);
      #1;
      checkValue("noGhostTxn", 32'({io.out_valid, io.in_ready}), 32'b01);
    end

`ifdef CMP_SIGNED_EN
    applyStimulus(16'hFFFF, 16'h0001, 1'b1);
    checkOutput(3'b001, 1, 0);
    applyStimulus(16'hFFFF, 16'h0001, 1'b0);
    checkOutput(3'b100, 1, 0);
`endif

    // Reset in the second CMP cycle discards the transaction.
    applyStimulus(16'h0000, 16'h0001, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    checkValue("midRstValid", 32'(io.out_valid), 32'd0);
    checkValue("midRstFlags", 32'({io.A_greater, io.A_equal, io.A_less}), 32'd0);
    checkValue("midRstReady", 32'(io.in_ready), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkValue("postRstReady", 32'(io.in_ready), 32'd1);
    repeat (6) begin
      @(posedge clk);
      #1;
      checkValue("discardedNeverValid", 32'({io.out_valid, io.A_greater, io.A_equal, io.A_less}), 32'd0);
    end
    applyStimulus(16'h9000, 16'h8000, 1'b0);
    checkOutput(3'b100, 1, 0);

    for (int t = 0; t < 24; t++) begin
      ra = WIDTH'($urandom);
      case ($urandom_range(0, 3))
        0:       rb = ra;
        1:       rb = {ra[WIDTH-1:8], 8'($urandom)};
        2:       rb = ra ^ WIDTH'(16'h0001 << $urandom_range(0, WIDTH - 1));
        default: rb = WIDTH'($urandom);
      endcase
`ifdef CMP_SIGNED_EN
      rsm = 1'($urandom);
`else
      rsm = 1'b0;
`endif
      refModel(ra, rb, rsm, expFlags, expK);
      if (!io.out_ready) io.out_ready = 1'b1;
      applyStimulus(ra, rb, rsm);
      checkOutput(expFlags, expK, $urandom_range(0, 2));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
